parallel_serial_tx: RTL and testbench

PARALLEL_SERIAL_TX -- requirements
Module: parallel_serial_tx

---
 rtl/parallel_serial_tx.sv | 184 ++++++++++++++++++
 tb/tb_parallel_serial_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: queues parallel words in a small FIFO and sends each one
// as a serial frame: start bit (0), N data bits (LSB- or MSB-first), optional
// even parity bit. The line is released (Z) between frames.
module parallel_serial_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dv_in,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [LEN_WIDTH-1:0]  bit_length,
   input  logic                  msb_first,
   input  logic                  parity_en,
   output logic                  dout,
   output logic                  dout_en,
   output logic                  data_sent,
   output logic                  ready,
   output logic                  overflow,
   output logic                  busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATA_WIDTH + LEN_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;

   // FIFO storage and bookkeeping
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  overflow_q;
   logic                  full_s;
   logic                  push_s;
   logic                  pop_s;
   logic [EW-1:0]         head_s;
   logic [LEN_WIDTH-1:0]  head_len_s;
   logic [LEN_WIDTH-1:0]  n_eff_s;

   // Transmitter state; everything here is frozen for the frame in flight
   state_t                state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [LEN_WIDTH-1:0]  n_q;
   logic [LEN_WIDTH-1:0]  cnt_q;
   logic                  msb_q;
   logic                  par_en_q;
   logic                  par_acc_q;
   logic                  dout_q;
   logic                  dout_en_q;
   logic                  data_sent_q;
   logic [LEN_WIDTH-1:0]  idx_s;
   logic                  bit_s;

   // Fullness comes from the registered count, so a same-edge pop never frees a slot for a write
   always_comb begin
      full_s     = (count_q == CW'(FIFO_DEPTH));
      push_s     = dv_in & ~full_s;
      pop_s      = (state_q == IDLE) & (count_q != '0);
      head_s     = mem_q[rd_ptr_q];
      head_len_s = head_s[LEN_WIDTH+1:2];
      if ((head_len_s == '0) || (head_len_s > LEN_WIDTH'(DATA_WIDTH))) begin
         n_eff_s = LEN_WIDTH'(DATA_WIDTH);
      end else begin
         n_eff_s = head_len_s;
      end
   end

   // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Select the data bit for the current count in the latched bit order
   always_comb begin
      if (msb_q) begin
         idx_s = n_q - LEN_WIDTH'(1) - cnt_q;
      end else begin
         idx_s = cnt_q;
      end
      bit_s = |(data_q & (DATA_WIDTH'(1) << idx_s));
   end

   // FIFO storage write (contents are don't-care until the count covers them)
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_q[wr_ptr_q] <= {din, bit_length, msb_first, parity_en};
      end
   end

   // FIFO pointers, occupancy and the overflow pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q    <= count_d;
         overflow_q <= dv_in & full_s;
      end
   end

   // Frame FSM with registered line outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         n_q         <= '0;
         cnt_q       <= '0;
         msb_q       <= 1'b0;
         par_en_q    <= 1'b0;
         par_acc_q   <= 1'b0;
         dout_q      <= 1'b0;
         dout_en_q   <= 1'b0;
         data_sent_q <= 1'b0;
      end else begin
         data_sent_q <= 1'b0;
         case (state_q)
            IDLE: begin
               dout_en_q <= 1'b0;
               if (pop_s) begin
                  data_q    <= head_s[EW-1:LEN_WIDTH+2];
                  n_q       <= n_eff_s;
                  msb_q     <= head_s[1];
                  par_en_q  <= head_s[0];
                  cnt_q     <= '0;
                  par_acc_q <= 1'b0;
                  state_q   <= START;
               end
            end
            START: begin
               dout_q    <= 1'b0;
               dout_en_q <= 1'b1;
               state_q   <= DATA;
            end
            DATA: begin
               if (cnt_q != n_q) begin
                  dout_q    <= bit_s;
                  par_acc_q <= par_acc_q ^ bit_s;
                  cnt_q     <= cnt_q + LEN_WIDTH'(1);
               end else if (par_en_q) begin
                  dout_q  <= par_acc_q;
                  state_q <= PARITY;
               end else begin
                  dout_en_q   <= 1'b0;
                  data_sent_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            PARITY: begin
               dout_en_q   <= 1'b0;
               data_sent_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               dout_en_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign dout      = dout_en_q ? dout_q : 1'bz;
   assign dout_en   = dout_en_q;
   assign data_sent = data_sent_q;
   assign overflow  = overflow_q;
   assign ready     = ~full_s;
   assign busy      = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_parallel_serial_tx.sv
// tb_parallel_serial_tx: directed-vector bench for parallel_serial_tx.
module tb_parallel_serial_tx;

   logic        clk;
   logic        rst;
   logic        dv_in;
   logic [15:0] din;
   logic [4:0]  bit_length;
   logic        msb_first;
   logic        parity_en;
   wire         dout;
   wire         dout_en;
   wire         data_sent;
   wire         ready;
   wire         overflow;
   wire         busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] cap_bits;
   int          ncap;
   logic [31:0] en_hist;
   int          nsent;

   parallel_serial_tx #(.DATA_WIDTH(16), .LEN_WIDTH(5), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .dv_in      (dv_in),
      .din        (din),
      .bit_length (bit_length),
      .msb_first  (msb_first),
      .parity_en  (parity_en),
      .dout       (dout),
      .dout_en    (dout_en),
      .data_sent  (data_sent),
      .ready      (ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_cap();
      tick();
      if (dout_en) begin
         cap_bits = {cap_bits[30:0], dout};
         ncap++;
      end
      en_hist = {en_hist[30:0], dout_en};
      if (data_sent) nsent++;
   endtask

   task automatic clear_cap();
      cap_bits = '0;
      ncap     = 0;
      en_hist  = '0;
      nsent    = 0;
   endtask

   task automatic set_word(input logic [15:0] d, input logic [4:0] n, input logic msb, input logic par);
      din        = d;
      bit_length = n;
      msb_first  = msb;
      parity_en  = par;
   endtask

   // Send one word into an idle block and check every line cycle against pat
   // (pat lists driven bits in time order, start bit first).
   task automatic send_and_check(input string tag, input logic [15:0] d, input logic [4:0] n,
                                 input logic msb, input logic par, input string pat);
      set_word(d, n, msb, par);
      dv_in = 1'b1;
      tick();
      dv_in = 1'b0;
      check_val({tag, "_busy_e0"}, busy, 1);
      tick();
      check_val({tag, "_en_e1"}, dout_en, 0);
      for (int i = 0; i < pat.len(); i++) begin
         tick();
         check_val($sformatf("%s_en_%0d", tag, i), dout_en, 1);
         check_val($sformatf("%s_bit_%0d", tag, i), dout, (pat[i] == 8'h31) ? 1 : 0);
         check_val($sformatf("%s_sent_%0d", tag, i), data_sent, 0);
      end
      tick();
      check_val({tag, "_en_end"}, dout_en, 0);
      check_val({tag, "_sent_end"}, data_sent, 1);
      tick();
      check_val({tag, "_sent_after"}, data_sent, 0);
      check_val({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      logic [15:0] w6 [6];
      w6 = '{16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0001, 16'h0002};
      rst   = 1'b1;
      dv_in = 1'b0;
      set_word(16'h0000, 5'd0, 1'b0, 1'b0);
      clear_cap();
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_en", dout_en, 0);
      check_val("rst_sent", data_sent, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_ready", ready, 1);
      check_val("rst_busy", busy, 0);

      // Basic frames, hand-derived bit patterns
      send_and_check("a5_lsb", 16'h00A5, 5'd8, 1'b0, 1'b0, "010100101");
      send_and_check("0b_msb_par", 16'h000B, 5'd4, 1'b1, 1'b1, "010111");
      send_and_check("13_lsb_par", 16'h0013, 5'd5, 1'b0, 1'b1, "0110011");
      send_and_check("f4_msb_n3", 16'hFFF4, 5'd3, 1'b1, 1'b1, "01001");
      send_and_check("n0", 16'hFFFF, 5'd0, 1'b0, 1'b0, "01111111111111111");
      send_and_check("n20", 16'hFFFF, 5'd20, 1'b0, 1'b0, "01111111111111111");

      // Six back-to-back writes into a 4-deep FIFO
      clear_cap();
      for (int i = 0; i < 6; i++) begin
         set_word(w6[i], 5'd2, 1'b0, 1'b0);
         dv_in = 1'b1;
         tick_cap();
         check_val($sformatf("ovf_e%0d", i), overflow, (i == 5) ? 1 : 0);
         check_val($sformatf("ready_e%0d", i), ready, (i < 4) ? 1 : 0);
      end
      dv_in = 1'b0;
      tick_cap();
      check_val("ovf_pulse_end", overflow, 0);
      for (int c = 0; c < 100 && !(nsent == 5 && !busy); c++) tick_cap();
      check_val("six_sent", nsent, 5);
      check_val("six_nbits", ncap, 15);
      check_val("six_stream", cap_bits[14:0], 15'b010001011000010);
      check_val("six_busy", busy, 0);

      // Two queued N=3 frames: exactly two Z cycles between them
      tick();
      clear_cap();
      set_word(16'h0007, 5'd3, 1'b0, 1'b0);
      dv_in = 1'b1;
      tick_cap();
      tick_cap();
      dv_in = 1'b0;
      for (int c = 0; c < 11; c++) tick_cap();
      check_val("gap_en_hist", en_hist[12:0], 13'b0011110011110);
      check_val("gap_sent", nsent, 2);

      // Reset during the 4th data bit with two words still queued
      tick();
      clear_cap();
      set_word(16'h00FF, 5'd8, 1'b0, 1'b1);
      dv_in = 1'b1;
      tick();
      tick();
      tick();
      dv_in = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check_val("pre_rst_en", dout_en, 1);
      check_val("pre_rst_busy", busy, 1);
      rst   = 1'b1;
      dv_in = 1'b1;
      tick();
      rst   = 1'b0;
      dv_in = 1'b0;
      check_val("mid_rst_en", dout_en, 0);
      check_val("mid_rst_sent", data_sent, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_ready", ready, 1);
      clear_cap();
      for (int c = 0; c < 30; c++) tick_cap();
      check_val("post_rst_sent", nsent, 0);
      check_val("post_rst_driven", ncap, 0);
      check_val("post_rst_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
